// File: rtl/uart_pkg.sv
// uart_pkg
// Shared constants for the UART debug transport: the command field and DTM
// instruction-register widths, the decoder command codes, and the
// read-arbiter state encoding.
package uart_pkg;

    localparam int CMDLENGTH = 3;
    localparam int IRLENGTH  = 5;

    localparam logic [CMDLENGTH-1:0] CMD_NOP       = 3'd0;
    localparam logic [CMDLENGTH-1:0] CMD_READ      = 3'd1;
    localparam logic [CMDLENGTH-1:0] CMD_WRITE     = 3'd2;
    localparam logic [CMDLENGTH-1:0] CMD_CONT_READ = 3'd3;
    localparam logic [CMDLENGTH-1:0] CMD_RESET     = 3'd4;

    // Read-arbiter FSM states; shared so the state can be observed.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_SEND = 3'd2,
        ST_CONT = 3'd3,
        ST_DONE = 3'd4
    } arb_state_e;

endpackage

// File: rtl/read_arbiter_if.sv
// read_arbiter_if
// Bundles the three handshakes of the read arbiter:
//   command port   READ_COMMAND_I / READ_ADDRESS_I / READ_ARBITER_VALID_I
//                  -> READ_ARBITER_READY_O
//   register port  REG_ADDR_O / REG_REQ_O -> REG_VALID_I / REG_DATA_I
//   transmit port  TX_DATA_O / TX_VALID_O -> TX_READY_I
// plus CONT_ACTIVE_O and dbg_state, the arbiter's current FSM state.
// Modports: slave = the arbiter, master = its environment.
interface read_arbiter_if #(
    parameter int DATA_WIDTH = 41
);
    import uart_pkg::*;

    logic [CMDLENGTH-1:0]  READ_COMMAND_I;
    logic [IRLENGTH-1:0]   READ_ADDRESS_I;
    logic                  READ_ARBITER_VALID_I;
    logic                  READ_ARBITER_READY_O;

    logic [IRLENGTH-1:0]   REG_ADDR_O;
    logic                  REG_REQ_O;
    logic                  REG_VALID_I;
    logic [DATA_WIDTH-1:0] REG_DATA_I;

    logic [7:0]            TX_DATA_O;
    logic                  TX_VALID_O;
    logic                  TX_READY_I;

    logic                  CONT_ACTIVE_O;
    arb_state_e            dbg_state;

    modport slave (
        input  READ_COMMAND_I, READ_ADDRESS_I, READ_ARBITER_VALID_I,
        input  REG_VALID_I, REG_DATA_I, TX_READY_I,
        output READ_ARBITER_READY_O, REG_ADDR_O, REG_REQ_O,
        output TX_DATA_O, TX_VALID_O, CONT_ACTIVE_O, dbg_state
    );

    modport master (
        output READ_COMMAND_I, READ_ADDRESS_I, READ_ARBITER_VALID_I,
        output REG_VALID_I, REG_DATA_I, TX_READY_I,
        input  READ_ARBITER_READY_O, REG_ADDR_O, REG_REQ_O,
        input  TX_DATA_O, TX_VALID_O, CONT_ACTIVE_O, dbg_state
    );

endinterface

// File: rtl/read_arbiter.sv
// read_arbiter
// Read side of the UART debug transport. Accepts read-class commands from
// the decoder, fetches the addressed DTM register and streams its value
// LSB-first as bytes to the UART transmitter. CMD_CONT_READ re-polls the
// same register after every frame until another command arrives at a frame
// boundary; CMD_RESET stops polling.
// Ports:
//   CLK_I  clock
//   RST_I  asynchronous active-high reset
//   bus    read_arbiter_if.slave (command, register and transmit ports)
//
// Handshake semantics (all three ports): a transfer happens on a rising
// edge where the producer's valid/req and the consumer's ready/valid are
// both high. The producer holds its payload stable until that edge and
// never withdraws it. The arbiter's own valid/req outputs are decoded from
// registered state only, so they never depend combinationally on the
// opposite side's ready/valid.
module read_arbiter
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 41
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    read_arbiter_if.slave bus
);

    localparam int NUM_BYTES = (DATA_WIDTH + 7) / 8;
    localparam int SHIFT_W   = NUM_BYTES * 8;
    localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);

    arb_state_e           state_q, state_d;
    logic [SHIFT_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic [IRLENGTH-1:0]  addr_q,  addr_d;
    logic                 cont_q,  cont_d;

    logic                 can_accept;
    logic                 accept;

    // Ready is taken straight from state; RST_I only masks it so it reads
    // 0 while reset is held.
    assign can_accept = (state_q == ST_IDLE) || (state_q == ST_CONT);
    assign accept     = can_accept && bus.READ_ARBITER_VALID_I;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        cont_d  = cont_q;

        case (state_q)
            ST_IDLE, ST_CONT: begin
                if (accept) begin
                    addr_d = bus.READ_ADDRESS_I;
                    case (bus.READ_COMMAND_I)
                        CMD_READ: begin
                            cont_d  = 1'b0;
                            state_d = ST_REQ;
                        end
                        CMD_CONT_READ: begin
                            cont_d  = 1'b1;
                            state_d = ST_REQ;
                        end
                        CMD_RESET: begin
                            cont_d  = 1'b0;
                            state_d = ST_DONE;
                        end
                        CMD_NOP, CMD_WRITE: begin
                            state_d = ST_DONE;
                        end
                        default: begin
                            state_d = ST_DONE;
                        end
                    endcase
                end else if (state_q == ST_CONT) begin
                    // No new command at the frame boundary: poll again.
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                if (bus.REG_VALID_I) begin
                    shift_d                 = '0;
                    shift_d[DATA_WIDTH-1:0] = bus.REG_DATA_I;
                    cnt_d                   = '0;
                    state_d                 = ST_SEND;
                end
            end

            ST_SEND: begin
                if (bus.TX_READY_I) begin
                    shift_d = shift_q >> 8;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BYTE) begin
                        state_d = cont_q ? ST_CONT : ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            cont_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            cont_q  <= cont_d;
        end
    end

    assign bus.READ_ARBITER_READY_O = can_accept && !RST_I;
    assign bus.REG_REQ_O            = (state_q == ST_REQ);
    assign bus.REG_ADDR_O           = addr_q;
    assign bus.TX_VALID_O           = (state_q == ST_SEND);
    assign bus.TX_DATA_O            = (state_q == ST_SEND) ? shift_q[7:0] : 8'h00;
    assign bus.CONT_ACTIVE_O        = cont_q;
    assign bus.dbg_state            = state_q;

endmodule

// File: tb/tb_read_arbiter.sv
// tb_read_arbiter
// Directed bench for read_arbiter: single read, transmit backpressure,
// register wait states, continuous polling, reset/write commands and an
// asynchronous reset in the middle of a frame. Transmitted bytes are
// checked against an expected queue filled with hand-computed values.
module tb_read_arbiter;
    import uart_pkg::*;

    logic clk;
    logic rst;

    read_arbiter_if #(.DATA_WIDTH(41)) bus ();

    read_arbiter #(.DATA_WIDTH(41)) dut (
        .CLK_I (clk),
        .RST_I (rst),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_bytes(input logic [47:0] v);
        for (int b = 0; b < 6; b++) exp_q.push_back(v[8*b +: 8]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every byte accepted by the transmitter must be the next
    // expected byte; a byte with nothing expected is a failure.
    always @(negedge clk) begin
        if (bus.TX_VALID_O && bus.TX_READY_I) begin
            n_checks++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL tx_extra: observed byte %0h expected no byte", bus.TX_DATA_O);
            end
            if (exp_q.size() > 0) check("tx_byte", 64'(bus.TX_DATA_O), 64'(exp_q.pop_front()));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        logic       stalled;
        logic [7:0] prev_data;

        rst                      = 1'b1;
        bus.READ_COMMAND_I       = CMD_NOP;
        bus.READ_ADDRESS_I       = '0;
        bus.READ_ARBITER_VALID_I = 1'b0;
        bus.REG_VALID_I          = 1'b0;
        bus.REG_DATA_I           = '0;
        bus.TX_READY_I           = 1'b0;

        // Reset state
        #2;
        check("rst_ready",  64'(bus.READ_ARBITER_READY_O), 64'd0);
        check("rst_req",    64'(bus.REG_REQ_O),            64'd0);
        check("rst_txv",    64'(bus.TX_VALID_O),           64'd0);
        check("rst_active", 64'(bus.CONT_ACTIVE_O),        64'd0);
        tick();
        rst = 1'b0;
        #1;
        check("idle_ready", 64'(bus.READ_ARBITER_READY_O), 64'd1);
        check("idle_state", 64'(bus.dbg_state),            64'(ST_IDLE));

        // ---- Single read, zero waits ----
        push_bytes(48'h00_12_34_56_78_9A);
        bus.READ_COMMAND_I       = CMD_READ;
        bus.READ_ADDRESS_I       = 5'h11;
        bus.READ_ARBITER_VALID_I = 1'b1;
        bus.REG_DATA_I           = 41'h0_1234_5678_9A;
        bus.REG_VALID_I          = 1'b1;
        bus.TX_READY_I           = 1'b1;
        tick();
        bus.READ_ARBITER_VALID_I = 1'b0;
        bus.READ_COMMAND_I       = CMD_NOP;
        check("sr_req",   64'(bus.REG_REQ_O),            64'd1);
        check("sr_addr",  64'(bus.REG_ADDR_O),           64'h11);
        check("sr_ready", 64'(bus.READ_ARBITER_READY_O), 64'd0);
        check("sr_txv0",  64'(bus.TX_VALID_O),           64'd0);
        tick();
        bus.REG_VALID_I = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("sr_txv",       64'(bus.TX_VALID_O),           64'd1);
            check("sr_ready_low", 64'(bus.READ_ARBITER_READY_O), 64'd0);
            tick();
        end
        check("sr_done_ready", 64'(bus.READ_ARBITER_READY_O), 64'd0);
        check("sr_done_txv",   64'(bus.TX_VALID_O),           64'd0);
        check("sr_done_state", 64'(bus.dbg_state),            64'(ST_DONE));
        tick();
        check("sr_idle_ready", 64'(bus.READ_ARBITER_READY_O), 64'd1);
        check("sr_q_empty",    64'(exp_q.size()),             64'd0);

        // ---- Transmit backpressure: ready pattern 1,0,0 ----
        push_bytes(48'h00_12_34_56_78_9A);
        bus.READ_COMMAND_I       = CMD_READ;
        bus.READ_ADDRESS_I       = 5'h11;
        bus.READ_ARBITER_VALID_I = 1'b1;
        bus.REG_VALID_I          = 1'b1;
        bus.TX_READY_I           = 1'b0;
        tick();
        bus.READ_ARBITER_VALID_I = 1'b0;
        tick();
        bus.REG_VALID_I = 1'b0;
        stalled   = 1'b0;
        prev_data = 8'h00;
        cyc       = 0;
        while (cyc < 40 && bus.TX_VALID_O) begin
            if (stalled) begin
                check("bp_hold_data",  64'(bus.TX_DATA_O),  64'(prev_data));
                check("bp_hold_valid", 64'(bus.TX_VALID_O), 64'd1);
            end
            prev_data      = bus.TX_DATA_O;
            bus.TX_READY_I = (cyc % 3 == 0);
            stalled        = !bus.TX_READY_I;
            tick();
            cyc++;
        end
        check("bp_cycles",  64'(cyc),                 64'd16);
        check("bp_txv_end", 64'(bus.TX_VALID_O),      64'd0);
        bus.TX_READY_I = 1'b1;
        tick();
        check("bp_idle",    64'(bus.dbg_state),       64'(ST_IDLE));
        check("bp_q_empty", 64'(exp_q.size()),        64'd0);

        // ---- Register wait states: REG_VALID_I after 5 cycles ----
        push_bytes(48'h01_55_00_00_00_C3);
        bus.READ_COMMAND_I       = CMD_READ;
        bus.READ_ADDRESS_I       = 5'h01;
        bus.READ_ARBITER_VALID_I = 1'b1;
        bus.REG_VALID_I          = 1'b0;
        bus.REG_DATA_I           = 41'h1FF_FFFF_FFFF;
        tick();
        bus.READ_ARBITER_VALID_I = 1'b0;
        bus.READ_ADDRESS_I       = 5'h1F;
        for (int i = 0; i < 5; i++) begin
            check("rw_req",  64'(bus.REG_REQ_O),  64'd1);
            check("rw_addr", 64'(bus.REG_ADDR_O), 64'h01);
            check("rw_txv",  64'(bus.TX_VALID_O), 64'd0);
            bus.REG_DATA_I = 41'({$urandom(), $urandom()});
            tick();
        end
        check("rw_req_last", 64'(bus.REG_REQ_O), 64'd1);
        bus.REG_VALID_I = 1'b1;
        bus.REG_DATA_I  = 41'h155_0000_00C3;
        tick();
        bus.REG_VALID_I = 1'b0;
        bus.REG_DATA_I  = 41'h0AB_CDEF_0123;
        check("rw_req_drop", 64'(bus.REG_REQ_O),  64'd0);
        check("rw_send",     64'(bus.TX_VALID_O), 64'd1);
        for (int i = 0; i < 6; i++) tick();
        tick();
        check("rw_idle",    64'(bus.READ_ARBITER_READY_O), 64'd1);
        check("rw_q_empty", 64'(exp_q.size()),             64'd0);

        // ---- Continuous read with new value per frame ----
        push_bytes(48'h00_AA_BB_CC_DD_EE);
        bus.READ_COMMAND_I       = CMD_CONT_READ;
        bus.READ_ADDRESS_I       = 5'h10;
        bus.READ_ARBITER_VALID_I = 1'b1;
        bus.REG_DATA_I           = 41'h0AA_BBCC_DDEE;
        bus.REG_VALID_I          = 1'b1;
        tick();
        bus.READ_ARBITER_VALID_I = 1'b0;
        bus.READ_COMMAND_I       = CMD_NOP;
        check("c_req",    64'(bus.REG_REQ_O),     64'd1);
        check("c_addr",   64'(bus.REG_ADDR_O),    64'h10);
        check("c_active", 64'(bus.CONT_ACTIVE_O), 64'd1);
        tick();
        bus.REG_DATA_I = 41'h102_0304_0506;
        push_bytes(48'h01_02_03_04_05_06);
        for (int i = 0; i < 6; i++) begin
            check("c_f1_txv", 64'(bus.TX_VALID_O), 64'd1);
            tick();
        end
        check("c_cont_state",  64'(bus.dbg_state),            64'(ST_CONT));
        check("c_cont_ready",  64'(bus.READ_ARBITER_READY_O), 64'd1);
        check("c_cont_txv",    64'(bus.TX_VALID_O),           64'd0);
        check("c_cont_active", 64'(bus.CONT_ACTIVE_O),        64'd1);
        tick();
        check("c_repoll_req",  64'(bus.REG_REQ_O),  64'd1);
        check("c_repoll_addr", 64'(bus.REG_ADDR_O), 64'h10);
        tick();
        // CMD_READ held from mid-frame; taken only at the frame boundary.
        bus.READ_COMMAND_I       = CMD_READ;
        bus.READ_ADDRESS_I       = 5'h11;
        bus.READ_ARBITER_VALID_I = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("c_f2_ready", 64'(bus.READ_ARBITER_READY_O), 64'd0);
            check("c_f2_txv",   64'(bus.TX_VALID_O),           64'd1);
            check("c_f2_addr",  64'(bus.REG_ADDR_O),           64'h10);
            tick();
        end
        check("c_cont2_ready", 64'(bus.READ_ARBITER_READY_O), 64'd1);
        bus.REG_DATA_I = 41'h0_1234_5678_9A;
        push_bytes(48'h00_12_34_56_78_9A);
        tick();
        bus.READ_ARBITER_VALID_I = 1'b0;
        bus.READ_COMMAND_I       = CMD_NOP;
        check("c_after_active", 64'(bus.CONT_ACTIVE_O), 64'd0);
        check("c_after_req",    64'(bus.REG_REQ_O),     64'd1);
        check("c_after_addr",   64'(bus.REG_ADDR_O),    64'h11);
        tick();
        for (int i = 0; i < 6; i++) tick();
        check("c_done_state", 64'(bus.dbg_state), 64'(ST_DONE));
        tick();
        check("c_idle_ready", 64'(bus.READ_ARBITER_READY_O), 64'd1);
        check("c_q_empty",    64'(exp_q.size()),             64'd0);

        // ---- CMD_RESET while polling ----
        push_bytes(48'h00_AA_BB_CC_DD_EE);
        bus.READ_COMMAND_I       = CMD_CONT_READ;
        bus.READ_ADDRESS_I       = 5'h10;
        bus.READ_ARBITER_VALID_I = 1'b1;
        bus.REG_DATA_I           = 41'h0AA_BBCC_DDEE;
        tick();
        bus.READ_ARBITER_VALID_I = 1'b0;
        tick();
        bus.READ_COMMAND_I       = CMD_RESET;
        bus.READ_ARBITER_VALID_I = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("r_cont_ready",  64'(bus.READ_ARBITER_READY_O), 64'd1);
        check("r_cont_active", 64'(bus.CONT_ACTIVE_O),        64'd1);
        tick();
        bus.READ_ARBITER_VALID_I = 1'b0;
        bus.READ_COMMAND_I       = CMD_NOP;
        check("r_active", 64'(bus.CONT_ACTIVE_O),        64'd0);
        check("r_req",    64'(bus.REG_REQ_O),            64'd0);
        check("r_txv",    64'(bus.TX_VALID_O),           64'd0);
        check("r_ready",  64'(bus.READ_ARBITER_READY_O), 64'd0);
        tick();
        check("r_idle", 64'(bus.READ_ARBITER_READY_O), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("r_quiet_txv", 64'(bus.TX_VALID_O), 64'd0);
        end
        check("r_q_empty", 64'(exp_q.size()), 64'd0);

        // ---- CMD_WRITE: accepted, no register request, no bytes ----
        bus.READ_COMMAND_I       = CMD_WRITE;
        bus.READ_ADDRESS_I       = 5'h11;
        bus.READ_ARBITER_VALID_I = 1'b1;
        tick();
        bus.READ_ARBITER_VALID_I = 1'b0;
        bus.READ_COMMAND_I       = CMD_NOP;
        check("w_req",    64'(bus.REG_REQ_O),            64'd0);
        check("w_txv",    64'(bus.TX_VALID_O),           64'd0);
        check("w_ready",  64'(bus.READ_ARBITER_READY_O), 64'd0);
        check("w_active", 64'(bus.CONT_ACTIVE_O),        64'd0);
        tick();
        check("w_idle",   64'(bus.READ_ARBITER_READY_O), 64'd1);

        // ---- Asynchronous reset during byte 3 ----
        exp_q.push_back(8'h9A);
        exp_q.push_back(8'h78);
        exp_q.push_back(8'h56);
        bus.READ_COMMAND_I       = CMD_READ;
        bus.READ_ADDRESS_I       = 5'h11;
        bus.READ_ARBITER_VALID_I = 1'b1;
        bus.REG_DATA_I           = 41'h0_1234_5678_9A;
        bus.REG_VALID_I          = 1'b1;
        tick();
        bus.READ_ARBITER_VALID_I = 1'b0;
        bus.READ_COMMAND_I       = CMD_NOP;
        tick();
        bus.REG_VALID_I = 1'b0;
        tick();
        tick();
        tick();
        check("ar_byte3", 64'(bus.TX_DATA_O), 64'h34);
        #2;
        rst = 1'b1;
        #1;
        check("ar_ready",  64'(bus.READ_ARBITER_READY_O), 64'd0);
        check("ar_req",    64'(bus.REG_REQ_O),            64'd0);
        check("ar_txv",    64'(bus.TX_VALID_O),           64'd0);
        check("ar_txdata", 64'(bus.TX_DATA_O),            64'd0);
        check("ar_addr",   64'(bus.REG_ADDR_O),           64'd0);
        check("ar_active", 64'(bus.CONT_ACTIVE_O),        64'd0);
        tick();
        rst = 1'b0;
        #1;
        check("ar_rel_ready", 64'(bus.READ_ARBITER_READY_O), 64'd1);
        check("ar_rel_state", 64'(bus.dbg_state),            64'(ST_IDLE));
        for (int i = 0; i < 5; i++) begin
            tick();
            check("ar_quiet_txv", 64'(bus.TX_VALID_O), 64'd0);
        end
        check("ar_q_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
